// File: rtl/operand_entry_if.sv
// Button inputs and packed operand outputs of the operand-entry stage.
interface operand_entry_if;
    logic       btn_inc;
    logic       btn_next;
    logic [7:0] operands;
    logic       op_valid;
    logic [1:0] entry_state;

    modport master (
        output btn_inc, btn_next,
        input  operands, op_valid, entry_state
    );

    modport slave (
        input  btn_inc, btn_next,
        output operands, op_valid, entry_state
    );
endinterface

// File: rtl/operand_entry.sv
// Debounced two-button entry of operands A/B for the nibble adder stage.
// Optional auto-repeat of a held increment button: OPERAND_ENTRY_AUTO_REPEAT_EN.
module operand_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned REPEAT_CYCLES   = 250000
) (
    input  logic            clk,
    input  logic            rst,
    operand_entry_if.slave  bus
);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        SHOW    = 2'd2
    } state_e;

    localparam int unsigned     DB_W    = 16;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 carries the increment button, bit 1 the next button.
    logic [1:0]      raw_c;
    logic [1:0]      sync1_q, sync2_q, stable_q, prev_q, press_q;
    logic [DB_W-1:0] cnt_q [2];

    state_e     state_q;
    logic [3:0] op_a_q, op_b_q;
    logic       valid_q;
    logic       inc_evt_c;

    assign raw_c = {bus.btn_next, bus.btn_inc};

    // Synchronize, debounce and edge-detect both buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            press_q  <= '0;
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= raw_c;
            sync2_q <= sync1_q;
            prev_q  <= stable_q;
            press_q <= stable_q & ~prev_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DB_LAST) begin
                    stable_q[i] <= sync2_q[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

`ifdef OPERAND_ENTRY_AUTO_REPEAT_EN
    localparam int unsigned      RPT_W    = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt_q;
    logic             rpt_press_q;

    // A next press always changes state, so it also restarts the repeat timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt_q   <= '0;
            rpt_press_q <= 1'b0;
        end else begin
            rpt_press_q <= 1'b0;
            if (!stable_q[0] || press_q[1] ||
                !(state_q == ENTER_A || state_q == ENTER_B)) begin
                rpt_cnt_q <= '0;
            end else if (rpt_cnt_q == RPT_LAST) begin
                rpt_cnt_q   <= '0;
                rpt_press_q <= 1'b1;
            end else begin
                rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
            end
        end
    end

    assign inc_evt_c = press_q[0] | rpt_press_q;
`else
    logic unused_repeat;
    assign unused_repeat = ^32'(REPEAT_CYCLES);
    assign inc_evt_c     = press_q[0];
`endif

    // Entry FSM; next outranks inc when both arrive together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ENTER_A;
            op_a_q  <= '0;
            op_b_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ENTER_A: begin
                    if (press_q[1])     state_q <= ENTER_B;
                    else if (inc_evt_c) op_a_q  <= op_a_q + 4'(1);
                end
                ENTER_B: begin
                    if (press_q[1]) begin
                        state_q <= SHOW;
                        valid_q <= 1'b1;
                    end else if (inc_evt_c) begin
                        op_b_q <= op_b_q + 4'(1);
                    end
                end
                SHOW: begin
                    if (press_q[1]) begin
                        state_q <= ENTER_A;
                        op_a_q  <= '0;
                        op_b_q  <= '0;
                    end
                end
                default: state_q <= ENTER_A;
            endcase
        end
    end

    assign bus.operands    = {op_a_q, op_b_q};
    assign bus.op_valid    = valid_q;
    assign bus.entry_state = 2'(state_q);

endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry: vector table plus reset/auto-repeat sequences.
module tb_operand_entry;

    localparam int unsigned DEB = 4;
    localparam int unsigned RPT = 20;

    localparam int ACT_INC    = 0;
    localparam int ACT_NEXT   = 1;
    localparam int ACT_BOTH   = 2;
    localparam int ACT_GLITCH = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    operand_entry_if bus ();

    operand_entry #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_CYCLES   (RPT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         act;
        int         reps;
        logic [7:0] ops;
        logic [1:0] st;
        bit         pulse;
    } vec_t;

    typedef struct {
        logic [7:0] ops;
        logic [1:0] st;
    } exp_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    exp_t       sb_q[$];
    logic [7:0] pulse_q[$];
    vec_t       vecs[14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Hold the chosen raw buttons for hold cycles, release, then let the release debounce.
    task automatic drive(input logic inc, input logic nxt, input int hold);
        @(posedge clk); #1;
        bus.btn_inc  = inc;
        bus.btn_next = nxt;
        repeat (hold) @(posedge clk);
        #1;
        bus.btn_inc  = 1'b0;
        bus.btn_next = 1'b0;
        repeat (20 - hold) @(posedge clk);
    endtask

    task automatic compare_front(input string name);
        exp_t e;
        @(negedge clk);
        e = sb_q.pop_front();
        check({name, "_operands"}, 32'(bus.operands), 32'(e.ops));
        check({name, "_state"}, 32'(bus.entry_state), 32'(e.st));
    endtask

    // Every op_valid pulse must match a committed pair and land on the first SHOW cycle.
    always @(negedge clk) begin
        if (!rst && bus.op_valid) begin
            if (pulse_q.size() == 0) begin
                check("op_valid_unexpected", 32'(bus.op_valid), 32'd0);
            end else begin
                check("op_valid_operands", 32'(bus.operands), 32'(pulse_q.pop_front()));
                check("op_valid_state", 32'(bus.entry_state), 32'd2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{ACT_INC,    3,  8'h30, 2'd0, 1'b0};
        vecs[1]  = '{ACT_NEXT,   1,  8'h30, 2'd1, 1'b0};
        vecs[2]  = '{ACT_INC,    5,  8'h35, 2'd1, 1'b0};
        vecs[3]  = '{ACT_NEXT,   1,  8'h35, 2'd2, 1'b1};
        vecs[4]  = '{ACT_NEXT,   1,  8'h00, 2'd0, 1'b0};
        vecs[5]  = '{ACT_GLITCH, 1,  8'h00, 2'd0, 1'b0};
        vecs[6]  = '{ACT_INC,    17, 8'h10, 2'd0, 1'b0};
        vecs[7]  = '{ACT_BOTH,   1,  8'h10, 2'd1, 1'b0};
        vecs[8]  = '{ACT_NEXT,   1,  8'h10, 2'd2, 1'b1};
        vecs[9]  = '{ACT_INC,    1,  8'h10, 2'd2, 1'b0};
        vecs[10] = '{ACT_NEXT,   1,  8'h00, 2'd0, 1'b0};
        vecs[11] = '{ACT_INC,    7,  8'h70, 2'd0, 1'b0};
        vecs[12] = '{ACT_NEXT,   1,  8'h70, 2'd1, 1'b0};
        vecs[13] = '{ACT_INC,    2,  8'h72, 2'd1, 1'b0};

        rst          = 1'b1;
        bus.btn_inc  = 1'b0;
        bus.btn_next = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_operands", 32'(bus.operands), 32'h00);
        check("reset_valid", 32'(bus.op_valid), 32'd0);
        check("reset_state", 32'(bus.entry_state), 32'd0);

        for (int v = 0; v < 14; v++) begin
            if (vecs[v].pulse) pulse_q.push_back(vecs[v].ops);
            for (int r = 0; r < vecs[v].reps; r++) begin
                case (vecs[v].act)
                    ACT_INC:  drive(1'b1, 1'b0, 10);
                    ACT_NEXT: drive(1'b0, 1'b1, 10);
                    ACT_BOTH: drive(1'b1, 1'b1, 10);
                    default:  drive(1'b1, 1'b0, 2);
                endcase
            end
            sb_q.push_back('{vecs[v].ops, vecs[v].st});
            compare_front($sformatf("vec%0d", v));
        end

        // Asynchronous reset in ENTER_B with 0x72, button held across release.
        @(posedge clk); #2;
        rst         = 1'b1;
        bus.btn_inc = 1'b1;
        sb_q.push_back('{8'h00, 2'd0});
        compare_front("rst_mid");
        check("rst_mid_valid", 32'(bus.op_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus.btn_inc = 1'b0;
        repeat (10) @(posedge clk);
        sb_q.push_back('{8'h10, 2'd0});
        compare_front("held_through_rst");

        // Press still inside the pipeline when reset hits must vanish.
        @(posedge clk); #1;
        bus.btn_inc = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rst         = 1'b1;
        bus.btn_inc = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        sb_q.push_back('{8'h00, 2'd0});
        compare_front("pending_press_dropped");

        // Long hold: one press, plus three repeats when auto-repeat is built in.
        @(posedge clk); #1;
        bus.btn_inc = 1'b1;
        repeat (DEB + 3 + 65) @(posedge clk);
        #1 bus.btn_inc = 1'b0;
        repeat (20) @(posedge clk);
`ifdef OPERAND_ENTRY_AUTO_REPEAT_EN
        sb_q.push_back('{8'h40, 2'd0});
`else
        sb_q.push_back('{8'h10, 2'd0});
`endif
        compare_front("long_hold");

        check("pulses_outstanding", 32'(pulse_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
